// File: rtl/cell_draw_engine.sv
// Draw-command consumer: paints one grid cell as a solid RGB565 rectangle over an
// 8-bit 8080-style LCD bus (CASET/PASET/RAMWR), then pulses cmd_done.
module cell_draw_engine #(
  parameter int CELL_W = 20,
  parameter int CELL_H = 20,
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       diff,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       err_oob,
  output logic [7:0] lcd_d,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic       lcd_csx,
  output logic [1:0] dbg_state
);

  localparam int NBYTES = 11 + 2 * CELL_W * CELL_H;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND_LO = 2'd1, SEND_HI = 2'd2, DONE = 2'd3} state_t;

  // Handshake: diff is a level request sampled only in IDLE; the request is
  // accepted on that edge and retired by the single-cycle cmd_done pulse.
  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [3:0]       x_q, y_q;
  logic [2:0]       obj_q;
  logic             oob_q, oob_n;
  logic             accept, req_oob, sending_n;
  logic [15:0]      xs, xe, ys, ye, colour;
  logic [7:0]       byte_n;
  logic             dcx_n;

  assign dbg_state = state;
  assign req_oob   = ({28'd0, y} >= 32'(GRID_H)) || ({28'd0, x} >= 32'(GRID_W));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    oob_n   = oob_q;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (diff) begin
          accept  = 1'b1;
          idx_n   = '0;
          oob_n   = req_oob;
          state_n = req_oob ? DONE : SEND_LO;
        end
      end
      SEND_LO: state_n = SEND_HI;
      SEND_HI: begin
        if (idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + IDX_W'(1);
          state_n = SEND_LO;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    xs = 16'(x_q) * 16'(CELL_W);
    xe = xs + 16'(CELL_W - 1);
    ys = 16'(y_q) * 16'(CELL_H);
    ye = ys + 16'(CELL_H - 1);
    case (obj_q)
      3'd0:    colour = 16'h0000;
      3'd1:    colour = 16'h03E0;
      3'd2:    colour = 16'h07E0;
      3'd3:    colour = 16'hF800;
      3'd4:    colour = 16'hFFFF;
      default: colour = 16'hF81F;
    endcase
  end

  // Byte for the index about to be driven. At accept idx_n is 0 (a constant
  // command byte), so the latched coordinates are settled before first use.
  // Pixel bytes start at odd index 11, so odd indices carry the high byte.
  always_comb begin
    case (idx_n)
      IDX_W'(0):  byte_n = 8'h2A;
      IDX_W'(1):  byte_n = xs[15:8];
      IDX_W'(2):  byte_n = xs[7:0];
      IDX_W'(3):  byte_n = xe[15:8];
      IDX_W'(4):  byte_n = xe[7:0];
      IDX_W'(5):  byte_n = 8'h2B;
      IDX_W'(6):  byte_n = ys[15:8];
      IDX_W'(7):  byte_n = ys[7:0];
      IDX_W'(8):  byte_n = ye[15:8];
      IDX_W'(9):  byte_n = ye[7:0];
      IDX_W'(10): byte_n = 8'h2C;
      default:    byte_n = idx_n[0] ? colour[15:8] : colour[7:0];
    endcase
    dcx_n     = !((idx_n == IDX_W'(0)) || (idx_n == IDX_W'(5)) || (idx_n == IDX_W'(10)));
    sending_n = (state_n == SEND_LO) || (state_n == SEND_HI);
  end

  // Bus pins are registered from the next state so the strobe is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      obj_q    <= '0;
      oob_q    <= 1'b0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      err_oob  <= 1'b0;
      lcd_d    <= 8'h00;
      lcd_dcx  <= 1'b1;
      lcd_wrx  <= 1'b1;
      lcd_csx  <= 1'b1;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      oob_q <= oob_n;
      if (accept) begin
        x_q   <= x;
        y_q   <= y;
        obj_q <= obj_code;
      end
      cmd_done <= (state_n == DONE);
      err_oob  <= (state_n == DONE) && oob_n;
      busy     <= (state_n != IDLE);
      lcd_csx  <= !sending_n;
      lcd_wrx  <= (state_n != SEND_LO);
      lcd_d    <= sending_n ? byte_n : 8'h00;
      lcd_dcx  <= sending_n ? dcx_n : 1'b1;
    end
  end

endmodule

// File: tb/tb_cell_draw_engine.sv
// Directed bench for cell_draw_engine: table of cell draws plus hand-written
// reset, back-to-back handshake and mid-stream reset sequences.
module tb_cell_draw_engine;

  logic       tb_clk = 1'b0;
  logic       rst, diff;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       cmd_done, busy, err_oob;
  logic [7:0] lcd_d;
  logic       lcd_dcx, lcd_wrx, lcd_csx;
  logic [1:0] dbg_state;

  always #5 tb_clk = ~tb_clk;

  cell_draw_engine dut (
    .clk(tb_clk), .rst(rst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
    .cmd_done(cmd_done), .busy(busy), .err_oob(err_oob),
    .lcd_d(lcd_d), .lcd_dcx(lcd_dcx), .lcd_wrx(lcd_wrx), .lcd_csx(lcd_csx),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [3:0]  x, y;
    logic [2:0]  obj;
    logic [15:0] xs, ys, colour;
    bit          oob;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int n_pass = 0, n_total = 0;
  int done_pulses = 0;
  logic [7:0] cap_q[$];
  logic       cap_dcx_q[$];
  logic [7:0] exp_q[$];

  always @(negedge tb_clk) if (cmd_done) done_pulses++;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Issues one request and samples every cycle until cmd_done (bounded).
  task automatic apply(input vec_t v, input int pre_edges, input int mut_cyc,
                       input bit keep_diff, input string tag);
    int done_cyc = -1, busy_bad = 0, stab_bad = 0, byte_bad = 0, dcx_lo = 0;
    int stray = 0;
    bit oob_seen = 0, prev_lo = 0;
    logic [7:0] lo_d = 8'h00;
    logic lo_dcx = 1'b1;
    logic [15:0] xe, ye;
    cap_q.delete(); cap_dcx_q.delete(); exp_q.delete();
    diff = 1'b1; x = v.x; y = v.y; obj_code = v.obj;
    repeat (pre_edges) @(posedge tb_clk);
    for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
      @(negedge tb_clk);
      if (c == mut_cyc) begin x = ~v.x; obj_code = v.obj ^ 3'd7; end
      if (!busy) busy_bad++;
      if (!lcd_wrx && lcd_csx) stray++;
      if (!lcd_csx && !lcd_wrx) begin
        cap_q.push_back(lcd_d); cap_dcx_q.push_back(lcd_dcx);
        lo_d = lcd_d; lo_dcx = lcd_dcx;
      end else if (prev_lo) begin
        if (lcd_csx !== 1'b0 || lcd_d !== lo_d || lcd_dcx !== lo_dcx) stab_bad++;
      end
      prev_lo = !lcd_csx && !lcd_wrx;
      if (err_oob && !cmd_done) stray++;
      if (cmd_done) begin
        done_cyc = c; oob_seen = err_oob;
        if (!keep_diff) diff = 1'b0;
      end
    end
    if (!v.oob) begin
      xe = v.xs + 16'd19; ye = v.ys + 16'd19;
      exp_q = '{8'h2A, v.xs[15:8], v.xs[7:0], xe[15:8], xe[7:0],
                8'h2B, v.ys[15:8], v.ys[7:0], ye[15:8], ye[7:0], 8'h2C};
      for (int p = 0; p < 400; p++) begin
        exp_q.push_back(v.colour[15:8]); exp_q.push_back(v.colour[7:0]);
      end
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      if (cap_q[i] !== exp_q[i]) byte_bad++;
      if (cap_dcx_q[i] !== !(i == 0 || i == 5 || i == 10)) byte_bad++;
      if (!cap_dcx_q[i]) dcx_lo++;
    end
    check({tag, "_latency"}, done_cyc, v.oob ? 1 : 1623);
    check({tag, "_err_oob"}, int'(oob_seen), int'(v.oob));
    check({tag, "_nbytes"}, cap_q.size(), exp_q.size());
    check({tag, "_bytes"}, byte_bad, 0);
    check({tag, "_dcx_cmds"}, dcx_lo, v.oob ? 0 : 3);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_stable"}, stab_bad, 0);
    check({tag, "_stray"}, stray, 0);
  endtask

  initial begin
    int lows, pulses0, rs_done, rs_lows;
    vecs[0] = '{4'd0,  4'd0,  3'd4, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
    vecs[1] = '{4'd15, 4'd11, 3'd3, 16'h012C, 16'h00DC, 16'hF800, 1'b0};
    vecs[2] = '{4'd3,  4'd5,  3'd1, 16'h003C, 16'h0064, 16'h03E0, 1'b0};
    vecs[3] = '{4'd7,  4'd2,  3'd2, 16'h008C, 16'h0028, 16'h07E0, 1'b0};
    vecs[4] = '{4'd1,  4'd9,  3'd0, 16'h0014, 16'h00B4, 16'h0000, 1'b0};
    vecs[5] = '{4'd10, 4'd6,  3'd6, 16'h00C8, 16'h0078, 16'hF81F, 1'b0};
    vecs[6] = '{4'd12, 4'd0,  3'd7, 16'h00F0, 16'h0000, 16'hF81F, 1'b0};
    vecs[7] = '{4'd0,  4'd12, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{4'd4,  4'd13, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[9] = '{4'd15, 4'd15, 3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b1};

    // Reset with diff held high
    rst = 1'b1; diff = 1'b1; x = 4'd0; y = 4'd0; obj_code = 3'd4; lows = 0;
    repeat (2) begin @(negedge tb_clk); if (!lcd_wrx) lows++; end
    check("rst_cmd_done", cmd_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err_oob", err_oob, 0);
    check("rst_lcd_d", lcd_d, 8'h00);
    check("rst_dcx", lcd_dcx, 1);
    check("rst_wrx", lcd_wrx, 1);
    check("rst_csx", lcd_csx, 1);
    check("rst_state", dbg_state, 0);
    check("rst_wrx_lows", lows, 0);
    rst = 1'b0; diff = 1'b0;
    @(negedge tb_clk);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], 1, 0, 1'b0, $sformatf("v%0d", i));
      @(negedge tb_clk);
      check($sformatf("v%0d_done_single", i), cmd_done, 0);
      check($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Held diff with mid-transfer input changes, then a back-to-back request
    repeat (3) @(negedge tb_clk);
    pulses0 = done_pulses;
    apply('{4'd2, 4'd3, 3'd1, 16'h0028, 16'h003C, 16'h03E0, 1'b0}, 1, 200, 1'b1, "hs1");
    apply('{4'd5, 4'd4, 3'd2, 16'h0064, 16'h0050, 16'h07E0, 1'b0}, 2, 0, 1'b0, "hs2");
    repeat (3) @(negedge tb_clk);
    check("hs_pulses", done_pulses - pulses0, 2);

    // Reset during pixel byte 300
    diff = 1'b1; x = 4'd5; y = 4'd5; obj_code = 3'd2;
    @(posedge tb_clk);
    repeat (601) @(negedge tb_clk);
    check("mr_byte300_d", lcd_d, 8'hE0);
    check("mr_byte300_wrx", lcd_wrx, 0);
    rst = 1'b1; diff = 1'b0;
    @(negedge tb_clk);
    check("mr_csx", lcd_csx, 1);
    check("mr_wrx", lcd_wrx, 1);
    check("mr_busy", busy, 0);
    rst = 1'b0; rs_done = 0; rs_lows = 0;
    repeat (1100) begin
      @(negedge tb_clk);
      if (cmd_done) rs_done++;
      if (!lcd_wrx) rs_lows++;
    end
    check("mr_no_done", rs_done, 0);
    check("mr_no_writes", rs_lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cell_draw_engine.md
Name: cell_draw_engine

Overview:
- Consumer end of the image generator's draw-command handshake.
- Accepts one changed grid cell per request: {x, y, obj_code} qualified by diff.
- Paints that cell as a CELL_W x CELL_H RGB565 rectangle over an 8-bit 8080-style LCD write bus (CASET/PASET/RAMWR).
- Pulses cmd_done so the generator advances its scan.

Parameters:
- CELL_W, 20, pixel width of one grid cell
- CELL_H, 20, pixel height of one grid cell
- GRID_W, 16, number of valid cell columns (x < GRID_W)
- GRID_H, 12, number of valid cell rows (y < GRID_H)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- diff  in  1  request valid: cell at (x,y) needs redraw; level, held by the generator until cmd_done
- x  in  4  cell column
- y  in  4  cell row
- obj_code  in  3  cell content
- cmd_done  out  1  one-cycle pulse: request finished (drawn or rejected)
- busy  out  1  high from accept through the cmd_done cycle
- err_oob  out  1  one-cycle pulse, coincident with cmd_done, when the request was out of range
- lcd_d  out  8  LCD data bus
- lcd_dcx  out  1  0 = command byte, 1 = data byte
- lcd_wrx  out  1  write strobe; the LCD latches on the rising edge
- lcd_csx  out  1  chip select, active-low

Behaviour:
- Reset values (the edge where rst=1): cmd_done=0, busy=0, err_oob=0, lcd_d=8'h00, lcd_dcx=1, lcd_wrx=1, lcd_csx=1, state=IDLE.
- Reset mid-operation aborts at once: no cmd_done, no further bus writes.
- States are IDLE, SEND_LO, SEND_HI, DONE.
- IDLE:
  - If diff=1, latch x, y, obj_code and set busy=1.
  - If y >= GRID_H or x >= GRID_W, go to DONE with err_oob flagged; no bus activity.
  - Otherwise, load byte index 0 and go to SEND_LO.
- Byte stream:
  - 2A, XS[15:8], XS[7:0], XE[15:8], XE[7:0], 2B, YS[15:8], YS[7:0], YE[15:8], YE[7:0], 2C.
  - Then CELL_W*CELL_H pixels, each sent as two bytes: colour[15:8] then colour[7:0].
  - Total = 11 + 2*CELL_W*CELL_H bytes, which is 811 at the defaults.
- Address arithmetic (16-bit, unsigned):
  - XS = x*CELL_W, XE = XS+CELL_W-1.
  - YS = y*CELL_H, YE = YS+CELL_H-1.
- lcd_dcx is 0 only for the 2A, 2B and 2C bytes.
- Colour per obj_code:
  - 0 empty = 16'h0000
  - 1 body = 16'h03E0
  - 2 head = 16'h07E0
  - 3 apple = 16'hF800
  - 4 border = 16'hFFFF
  - 5-7 reserved = 16'hF81F
- Each byte takes 2 cycles:
  - SEND_LO: lcd_csx=0, lcd_d/lcd_dcx driven, lcd_wrx=0.
  - SEND_HI: same lcd_d/lcd_dcx, lcd_wrx=1.
  - Data is stable across the rising edge of lcd_wrx.
- SEND_HI transitions:
  - If the byte index is the last one, go to DONE.
  - Otherwise, increment the index and return to SEND_LO.
- Pixel counter and byte counter wrap only via reload in IDLE; there is no free-running wrap.
- DONE (one cycle): cmd_done=1, err_oob as flagged, lcd_csx=1, lcd_wrx=1. Next state is IDLE; busy drops entering IDLE.
- Latency (accept edge = E0):
  - Bytes occupy cycles 1..1622.
  - cmd_done is high in cycle 1623.
  - For an OOB request, cmd_done is high in cycle 1.
- diff is ignored in every state except IDLE, including DONE. A diff still high in the cycle after DONE is treated as a new request.
- Inputs x, y and obj_code changing while busy have no effect.

Test Plan:
- Reset: assert rst 2 cycles with diff=1 -> all outputs at reset values, busy=0, no lcd_wrx low.
- Draw x=0,y=0,obj=4:
  - Captured byte stream is 2A 00 00 00 13 2B 00 00 00 13 2C followed by 800 bytes of FF.
  - dcx=0 on exactly 3 bytes.
  - cmd_done is a single pulse 1623 cycles after accept.
- Draw x=15,y=11,obj=3 -> header 2A 01 2C 01 3F 2B 00 DC 00 EF 2C, then 400 pairs F8 00; err_oob=0.
- Out-of-range y=13, diff=1 -> cmd_done and err_oob high 1 cycle after accept; lcd_csx stays 1; no lcd_wrx activity.
- Handshake:
  - Hold diff=1 through a draw with x/obj_code changed mid-transfer -> stream uses the latched values.
  - A second request starts the cycle after DONE.
  - Exactly 2 cmd_done pulses result from 2 requests.
- Reset mid-stream: assert rst at byte 300 -> next cycle lcd_csx=1, lcd_wrx=1, busy=0, and no cmd_done ever issued for that request.
